// File: rtl/sequence_frame_tx.sv
// ============================================================================
//  Module      : sequence_frame_tx
//  Description : Serialises a parallel payload MSB-first behind a 4-bit sync
//                preamble, followed by a run of '0' gap bits. Optional
//                even-parity bit after the payload when SEQ_TX_PARITY_EN is
//                defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sequence_frame_tx #(
    parameter int         WIDTH    = 8,
    parameter logic [3:0] PREAMBLE = 4'b1011,
    parameter int         GAP_LEN  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             out_en,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             frame_done,
    output logic             busy,
    output logic [2:0]       state_out,
    output logic [15:0]      frame_count
);

    localparam logic [2:0] S_IDLE     = 3'b000;
    localparam logic [2:0] S_PREAMBLE = 3'b001;
    localparam logic [2:0] S_PAYLOAD  = 3'b010;
    localparam logic [2:0] S_PARITY   = 3'b011;
    localparam logic [2:0] S_GAP      = 3'b100;

    // One counter walks preamble, payload and gap, so size it for the longest.
    localparam int CNT_MAX = (WIDTH > 15) ? WIDTH : 15;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] c_pre_last = CW'(3);
    localparam logic [CW-1:0] c_pay_last = CW'(WIDTH - 1);
    localparam logic [CW-1:0] c_gap_last = (GAP_LEN > 0) ? CW'(GAP_LEN - 1) : '0;
    localparam logic [2:0]    c_tail     = (GAP_LEN > 0) ? S_GAP : S_IDLE;
`ifdef SEQ_TX_PARITY_EN
    localparam logic [2:0]    c_after_pay = S_PARITY;
`else
    localparam logic [2:0]    c_after_pay = c_tail;
`endif

    logic [2:0]       state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             serial_out_q, serial_out_d;
    logic             serial_valid_q, serial_valid_d;
    logic             frame_done_q, frame_done_d;
    logic [15:0]      frame_count_q, frame_count_d;
    logic             frame_end;
`ifdef SEQ_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    always_comb begin
        state_d        = state_q;
        shift_d        = shift_q;
        cnt_d          = cnt_q;
        serial_out_d   = serial_out_q;
        serial_valid_d = 1'b0;
        frame_done_d   = 1'b0;
        frame_count_d  = frame_count_q;
        frame_end      = 1'b0;
`ifdef SEQ_TX_PARITY_EN
        parity_d       = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    shift_d = in_data;
                    cnt_d   = '0;
                    state_d = S_PREAMBLE;
`ifdef SEQ_TX_PARITY_EN
                    parity_d = 1'b0;
`endif
                end
            end
            S_PREAMBLE: begin
                if (out_en) begin
                    // 3-cnt == ~cnt for a 2-bit index: bit 3 goes first.
                    serial_out_d   = PREAMBLE[~cnt_q[1:0]];
                    serial_valid_d = 1'b1;
                    if (cnt_q == c_pre_last) begin
                        cnt_d   = '0;
                        state_d = S_PAYLOAD;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_PAYLOAD: begin
                if (out_en) begin
                    serial_out_d   = shift_q[WIDTH-1];
                    serial_valid_d = 1'b1;
                    shift_d        = shift_q << 1;
`ifdef SEQ_TX_PARITY_EN
                    parity_d       = parity_q ^ shift_q[WIDTH-1];
`endif
                    if (cnt_q == c_pay_last) begin
                        cnt_d     = '0;
                        state_d   = c_after_pay;
                        frame_end = (c_after_pay == S_IDLE);
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
`ifdef SEQ_TX_PARITY_EN
            S_PARITY: begin
                if (out_en) begin
                    serial_out_d   = parity_q;
                    serial_valid_d = 1'b1;
                    cnt_d          = '0;
                    state_d        = c_tail;
                    frame_end      = (c_tail == S_IDLE);
                end
            end
`endif
            S_GAP: begin
                if (out_en) begin
                    serial_out_d   = 1'b0;
                    serial_valid_d = 1'b1;
                    if (cnt_q >= c_gap_last) begin
                        cnt_d     = '0;
                        state_d   = S_IDLE;
                        frame_end = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (frame_end) begin
            frame_done_d  = 1'b1;
            frame_count_d = frame_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            shift_q        <= '0;
            cnt_q          <= '0;
            serial_out_q   <= 1'b0;
            serial_valid_q <= 1'b0;
            frame_done_q   <= 1'b0;
            frame_count_q  <= 16'd0;
`ifdef SEQ_TX_PARITY_EN
            parity_q       <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            shift_q        <= shift_d;
            cnt_q          <= cnt_d;
            serial_out_q   <= serial_out_d;
            serial_valid_q <= serial_valid_d;
            frame_done_q   <= frame_done_d;
            frame_count_q  <= frame_count_d;
`ifdef SEQ_TX_PARITY_EN
            parity_q       <= parity_d;
`endif
        end
    end

    assign in_ready     = (state_q == S_IDLE);
    assign busy         = (state_q != S_IDLE);
    assign state_out    = state_q;
    assign serial_out   = serial_out_q;
    assign serial_valid = serial_valid_q;
    assign frame_done   = frame_done_q;
    assign frame_count  = frame_count_q;

endmodule

`default_nettype wire

// File: doc/sequence_frame_tx.md
Name: sequence_frame_tx

Overview:
Transmit-side companion of the serial "1011" pattern detector. Accepts a parallel payload word on a valid/ready handshake and serialises it MSB-first behind the 4-bit sync preamble 1011. The frame ends with a trailing run of '0' gap bits. Output is the data/valid serial stream the detector consumes, with a stall input used to emulate valid gaps.

Parameters:
- WIDTH, 8, payload bits per frame (>=1).
- PREAMBLE, 4'b1011, sync pattern; sent bit 3 first.
- GAP_LEN, 2, trailing '0' bits per frame (0..15); 0 skips the GAP state.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_data  in  WIDTH  payload word
- in_valid  in  1  payload offered
- in_ready  out  1  combinational; 1 iff state==IDLE
- out_en  in  1  advance enable; 0 = stall, no bit emitted that cycle
- serial_out  out  1  registered serial bit
- serial_valid  out  1  registered; serial_out is meaningful
- frame_done  out  1  registered 1-cycle pulse, coincident with the last bit of a frame
- busy  out  1  combinational; state!=IDLE
- state_out  out  3  current state, for verification
- frame_count  out  16  frames completed; wraps 0xFFFF->0

Behaviour:
- Reset (async, any time, including mid-frame):
  - state=IDLE; serial_out=0, serial_valid=0, frame_done=0, frame_count=0.
  - Shift register and bit counter cleared. A partial frame is discarded and never resumed.
- States: IDLE=000, PREAMBLE=001, PAYLOAD=010, PARITY=011 (macro only), GAP=100. Other codes go to IDLE on the next edge.
- IDLE:
  - serial_valid<=0 every edge.
  - in_valid && in_ready at an edge: capture in_data into the shift register, clear the bit counter, go to PREAMBLE.
  - Acceptance does not depend on out_en.
- Emission, in every non-IDLE state at an edge:
  - out_en=1: serial_out<=current bit, serial_valid<=1, advance counter/shift.
  - out_en=0: serial_valid<=0; serial_out, counter and state hold.
- PREAMBLE: emit PREAMBLE[3],[2],[1],[0]. After the 4th bit go to PAYLOAD.
- PAYLOAD: emit in_data[WIDTH-1] down to [0]. After the last bit go to:
  - PARITY, if the macro is enabled;
  - else GAP, if GAP_LEN>0;
  - else IDLE.
- GAP: emit GAP_LEN '0' bits, then go to IDLE.
- Last bit of a frame, on the same edge:
  - frame_done<=1; frame_count<=frame_count+1 (mod 2^16); state<=IDLE.
  - frame_done is 0 on all other edges.
- Latency: word accepted at edge E0 → first preamble bit registered at E1 (given out_en=1).
- Back-to-back frames: last bit at Ek, next word accepted at Ek+1 (serial_valid=0 that cycle), first bit at Ek+2. There is exactly one bubble cycle between frames.
- Frame length in valid bits: 4 + WIDTH + P + GAP_LEN, where P=1 with the macro, else 0.
- in_data is sampled only at acceptance; later changes have no effect.
- The payload is not scrubbed. A payload containing 1011 can produce a detector hit; that is the sink's concern.

Optional Feature:
- Macro SEQ_TX_PARITY_EN.
- Defined: the PARITY state follows PAYLOAD and emits one even-parity bit (XOR of all payload bits), then goes to GAP or IDLE. Frame length +1.
- Undefined: the PARITY state and its logic are absent; PAYLOAD goes directly to GAP/IDLE; code 011 is treated as illegal and returns to IDLE.

Test Plan:
- Single frame: WIDTH=8, GAP_LEN=2, in_data=0xA5, out_en=1, no macro.
  - serial_out over 14 valid cycles = 1,0,1,1,1,0,1,0,0,1,0,1,0,0.
  - frame_done on the 14th bit; frame_count=1.
  - With the macro: parity 0 is inserted before the gap (15 bits).
- Stall: same frame with out_en=0 for 3 cycles after the 6th bit.
  - serial_valid=0 for those 3 cycles; serial_out holds the 6th bit.
  - Sequence resumes unchanged; total 14 valid bits.
- Back-to-back: in_valid held high with 0xFF then 0x00.
  - Exactly one serial_valid=0 cycle between frames; the second frame's payload is eight 0s; frame_count=2.
- Reset mid-frame: rst_n low during PAYLOAD bit 3.
  - All outputs 0 immediately; state_out=000; frame_count=0.
  - After release, in_ready=1 and the next frame starts with preamble 1011.
- Loopback: connect serial_out/serial_valid to the detector's data_in/valid_in, send 0x00.
  - Detector flags the pattern exactly once per frame, after the 4th bit.
- Counter wrap: force 65536 frames (WIDTH=1, GAP_LEN=0).
  - frame_count goes 0xFFFF→0x0000 with no other disturbance.
